systolic_drain: RTL and testbench
=================================

// Module: systolic_drain
// PURPOSE
//  Output-side collector for the 4x4 weight-stationary systolic core.
//  Column results Re1..Re4 leave the core skewed by one cycle per column.
//  This block de-skews them into one aligned 4x64 row vector per input vector.
//  It buffers those vectors in a FIFO and presents them on a valid/ready
//  stream, with job framing through start/busy/done/last.
//  The core cannot be stalled. Downstream backpressure is absorbed by the FIFO;
//  overflow is flagged, never propagated.
// PARAMETERS
//  BASE_LAT    4   cycles from the start sample edge to Re1 of vector 0
//  FIFO_DEPTH  8   aligned-vector FIFO entries (power of two, >=2)
//  CNT_W       8   width of num_vec and the vector counters
// PORTS
//  clk        in   1        clock, all logic on rising edge
//  rst        in   1        asynchronous, active-low reset
//  start      in   1        job start strobe, sampled only in IDLE
//  num_vec    in   CNT_W    vectors in job, sampled with start
//  Re1..Re4   in   64 each  core column outputs, column 0..3
//  out_valid  out  1        FIFO head valid
//  out_ready  in   1        downstream accepts head
//  out_data   out  256      {Re4,Re3,Re2,Re1} of one aligned vector
//  out_last   out  1        head is final vector of job
//  busy       out  1        high in any state other than IDLE
//  done       out  1        one-cycle pulse at job completion
//  overflow   out  1        sticky: a vector was dropped, FIFO full
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE; FIFO empty; counters=0; skew regs=0.
//   - out_valid, out_last, busy, done, overflow = 0; out_data = 0.
//  Timing contract: start sampled at edge of cycle 0.
//   - Column j of vector k is valid on the core output in cycle BASE_LAT+k+j.
//  De-skew (free-running, every cycle):
//   - Re1 delayed 3 cycles, Re2 2 cycles, Re3 1 cycle, Re4 0 cycles.
//   - The aligned vector k is present in cycle BASE_LAT+3+k.
//  FSM:
//   - IDLE:
//     - start & num_vec!=0: latch num_vec, clear overflow, load lat_cnt=BASE_LAT+3 -> WAIT.
//     - start & num_vec==0: done pulses next cycle; stay IDLE.
//   - WAIT: lat_cnt decrements each cycle; -> CAP when it reaches 0.
//   - CAP: push one aligned vector per cycle, num_vec pushes back-to-back.
//     - The final push carries last=1.
//     - -> DRAIN after the final push.
//   - DRAIN: -> IDLE when the FIFO is empty. done=1 for exactly one cycle on the transition.
//   - start is ignored while busy. No queuing and no restart.
//  FIFO:
//   - Pop when out_valid & out_ready.
//   - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//   - Otherwise the vector is dropped and overflow is set. The push counter still advances.
//   - If the dropped vector carried last, DRAIN still ends at empty.
//   - done still pulses; out_last is then never seen for that job.
//   - out_data/out_last held stable while out_valid & !out_ready.
//   - Earliest out_valid for vector k: cycle BASE_LAT+4+k.
//  Widths: data passed through unmodified; no arithmetic on results.
//  Reset mid-job: aborts immediately; FIFO contents discarded; no done pulse.
// TESTING
//  - T1 single vector: num_vec=1, core drives Re1..Re4=1,2,3,4 at cycles 4,5,6,7, ready=1
//    -> cycle 8: out_valid=1, out_data={4,3,2,1}, out_last=1; done pulses once afterwards.
//  - T2 burst: num_vec=4, vector k columns = 16k+j, ready=1
//    -> 4 consecutive out_valid cycles 8..11, each de-skewed correctly; last only on 4th.
//  - T3 backpressure: num_vec=10, ready=0 throughout
//    -> 8 entries held, overflow=1, vectors 8,9 lost.
//    -> Raise ready: 8 pops in order; done pulses after the 8th.
//  - T4 zero-length: start with num_vec=0 -> busy stays 0; done=1 next cycle; no out_valid.
//  - T5 start while busy: second start during CAP with num_vec=5
//    -> ignored; job completes with original count.
//  - T6 async reset in CAP after 2 pushes
//    -> outputs 0 immediately (no clock edge needed); next job runs cleanly, overflow=0.

Source files
------------

// File: rtl/systolic_drain.sv
// systolic_drain: de-skews the 4 systolic column outputs into aligned row vectors,
// buffers them in a FIFO and streams them out with job framing.
module systolic_drain #(
    parameter int BASE_LAT   = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_vec_i,
    input  logic [63:0]      re1_i,
    input  logic [63:0]      re2_i,
    input  logic [63:0]      re3_i,
    input  logic [63:0]      re4_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [255:0]     out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LAT_W = $clog2(BASE_LAT + 4);
    typedef enum logic [1:0] {IDLE, WAIT, CAP, DRAIN} state_t;
    state_t state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] nvec_q, nvec_d, push_q, push_d;
    logic [63:0] r1a_q, r1b_q, r1c_q, r2a_q, r2b_q, r3a_q;
    logic [256:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [PTR_W:0] cnt_q, cnt_d;
    logic done_q, done_d, ovf_q, ovf_d;
    logic start_ok, job_ok, push, pop, accept, last_push, empty;
    logic [255:0] aligned;
    assign start_ok  = (state_q == IDLE) && start_i;
    assign job_ok    = start_ok && (num_vec_i != '0);
    assign empty     = (cnt_q == '0);
    assign push      = (state_q == CAP);
    assign last_push = push && (push_q == nvec_q - CNT_W'(1));
    assign pop       = out_valid_o && out_ready_i;
    // The core cannot stall, so a push into a full FIFO is only taken when a pop frees a slot.
    assign accept    = push && ((cnt_q != (PTR_W+1)'(FIFO_DEPTH)) || pop);
    assign aligned   = {re4_i, r3a_q, r2b_q, r1c_q};
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = job_ok ? WAIT : IDLE;
            WAIT:    state_d = (lat_q == LAT_W'(1)) ? CAP : WAIT;
            CAP:     state_d = last_push ? DRAIN : CAP;
            DRAIN:   state_d = empty ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        lat_d  = job_ok ? LAT_W'(BASE_LAT + 3) : (state_q == WAIT) ? lat_q - LAT_W'(1) : lat_q;
        nvec_d = job_ok ? num_vec_i : nvec_q;
        push_d = job_ok ? '0 : push ? push_q + CNT_W'(1) : push_q;
        cnt_d  = cnt_q + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);
        ovf_d  = job_ok ? 1'b0 : ovf_q | (push & ~accept);
        done_d = (start_ok && (num_vec_i == '0)) || ((state_q == DRAIN) && empty);
    end
    always_comb begin
        busy_o      = (state_q != IDLE);
        out_valid_o = !empty;
        out_data_o  = out_valid_o ? mem[rd_q][255:0] : '0;
        out_last_o  = out_valid_o & mem[rd_q][256];
        done_o      = done_q;
        overflow_o  = ovf_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lat_q   <= '0;
            nvec_q  <= '0;
            push_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            r1a_q   <= '0;
            r1b_q   <= '0;
            r1c_q   <= '0;
            r2a_q   <= '0;
            r2b_q   <= '0;
            r3a_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            nvec_q  <= nvec_d;
            push_q  <= push_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_q + PTR_W'(accept);
            rd_q    <= rd_q + PTR_W'(pop);
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            r1a_q   <= re1_i;
            r1b_q   <= r1a_q;
            r1c_q   <= r1b_q;
            r2a_q   <= re2_i;
            r2b_q   <= r2a_q;
            r3a_q   <= re3_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (accept) mem[wr_q] <= {last_push, aligned};
    end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: scoreboard bench driving a skewed core model into systolic_drain.
module tb_systolic_drain;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [7:0] num_vec = '0;
    logic [63:0] re1 = '0, re2 = '0, re3 = '0, re4 = '0;
    logic out_valid, out_last, busy, done, overflow;
    logic [255:0] out_data;
    int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, voff = 0;
    logic [256:0] sb[$];
    logic hold = 1'b0;
    logic [256:0] held;
    systolic_drain dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_vec_i(num_vec),
        .re1_i(re1), .re2_i(re2), .re3_i(re3), .re4_i(re4),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .busy_o(busy), .done_o(done), .overflow_o(overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - t0);
    endtask
    function automatic logic [63:0] val(input logic [31:0] tag, input int k, input int j);
        return {tag, 32'(16 * k + j + voff)};
    endfunction
    function automatic logic [63:0] col(input logic [31:0] tag, input int c, input int j, input int n);
        int k = c - 4 - j;
        return (k >= 0 && k < n) ? val(tag, k, j) : {$urandom(), $urandom()};
    endfunction
    always @(negedge clk) begin
        if (!rst_n) hold = 1'b0;
        else begin
            if (hold) chk("hold", {out_last, out_data}, held);
            hold = out_valid && !out_ready;
            held = {out_last, out_data};
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("extra_pop", 257'(1), 257'(0));
                else chk("data", {out_last, out_data}, sb.pop_front());
            end
        end
    end
    task automatic job(input int n, input logic rdy, input int keep, input logic restart,
                       input int abort_at, input logic [31:0] tag);
        out_ready = rdy;
        for (int k = 0; k < keep; k++)
            sb.push_back({k == n - 1, val(tag, k, 3), val(tag, k, 2), val(tag, k, 1), val(tag, k, 0)});
        start = 1'b1;
        num_vec = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        for (int c = 0; c < n + 8; c++) begin
            re1 = col(tag, c, 0, n);
            re2 = col(tag, c, 1, n);
            re3 = col(tag, c, 2, n);
            re4 = col(tag, c, 3, n);
            start = restart && c == 8;
            num_vec = restart ? 8'd5 : num_vec;
            if (c == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_valid", 257'(out_valid), 257'(0));
                chk("rst_data", 257'(out_data), 257'(0));
                chk("rst_busy", 257'(busy), 257'(0));
                chk("rst_ovf", 257'(overflow), 257'(0));
                sb.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (c == 0) chk("busy_c0", 257'(busy), 257'(1));
            if (rdy) chk("valid_cyc", 257'(out_valid), 257'(c >= 8 && c < 8 + n));
            @(posedge clk); #1;
        end
    endtask
    task automatic wait_done(input string tag, input int exp_cyc);
        logic seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_done"}, 257'(seen), 257'(1));
        if (seen) begin
            chk({tag, "_done_cyc"}, 257'(cyc - t0), 257'(exp_cyc));
            chk({tag, "_idle"}, 257'(busy), 257'(0));
            @(posedge clk); #1;
            chk({tag, "_done_once"}, 257'(done), 257'(0));
        end
        chk({tag, "_sb_empty"}, 257'(sb.size()), 257'(0));
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {out_valid, out_last, busy, done, overflow, 252'(out_data)}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        voff = 1;
        job(1, 1'b1, 1, 1'b0, -1, 32'h0);
        wait_done("t1", 10);
        voff = 0;
        job(4, 1'b1, 4, 1'b0, -1, 32'h0);
        wait_done("t2", 13);
        job(10, 1'b0, 8, 1'b0, -1, 32'hA5A5_0003);
        chk("t3_ovf", 257'(overflow), 257'(1));
        chk("t3_held", 257'(out_valid), 257'(1));
        chk("t3_busy", 257'(busy), 257'(1));
        chk("t3_no_done", 257'(done), 257'(0));
        out_ready = 1'b1;
        wait_done("t3", 27);
        chk("t3_ovf_sticky", 257'(overflow), 257'(1));
        start = 1'b1;
        num_vec = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        chk("t4_done", 257'(done), 257'(1));
        chk("t4_busy", 257'(busy), 257'(0));
        chk("t4_valid", 257'(out_valid), 257'(0));
        @(posedge clk); #1;
        chk("t4_done_once", 257'(done), 257'(0));
        chk("t4_busy2", 257'(busy), 257'(0));
        job(6, 1'b0, 6, 1'b0, 9, 32'h6666_0006);
        job(2, 1'b1, 2, 1'b0, -1, 32'h7777_0007);
        wait_done("t6", 11);
        chk("t6_ovf", 257'(overflow), 257'(0));
        job(3, 1'b1, 3, 1'b1, -1, 32'h5555_0005);
        wait_done("t5", 12);
        repeat (12) @(posedge clk);
        #1;
        chk("t5_idle", 257'(busy), 257'(0));
        chk("t5_sb", 257'(sb.size()), 257'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
